axi_burst_addr_gen: RTL and testbench

- Parametrised successor to the single-mode AW beat counter.
- Accepts one AXI4 AW burst at a time and emits a backpressurable stream of per-beat addresses, one per W data beat.
- Supports FIXED, INCR and WRAP bursts, narrow transfers (awsize below bus width) and unaligned INCR/FIXED start addresses.
- Each beat carries ID, byte-lane offset and last flag so the W-path can steer and close the burst; runs back-to-back bursts with no idle cycle.

---
 rtl/axi_burst_addr_gen.sv | 158 +++++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_addr_gen.sv
// AXI4 AW burst to per-beat address stream (FIXED/INCR/WRAP, narrow, unaligned).
// Define AXI_BURST_ADDR_GEN_ERR_EN to add the o_err/o_err_code illegal-burst report.
module axi_burst_addr_gen #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH = 4,
    localparam int LW = $clog2(DATA_WIDTH / 8),
    localparam int LANE_W = (LW > 0) ? LW : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic [7:0]            i_awlen,
    input  logic [2:0]            i_awsize,
    input  logic [1:0]            i_awburst,
    input  logic [ID_WIDTH-1:0]   i_awid,
    input  logic                  i_awvalid,
    output logic                  i_awready,
    output logic [ADDR_WIDTH-1:0] o_beat_addr,
    output logic [LANE_W-1:0]     o_beat_lane,
    output logic [ID_WIDTH-1:0]   o_beat_id,
    output logic                  o_beat_last,
    output logic                  o_beat_valid,
    input  logic                  o_beat_ready
`ifdef AXI_BURST_ADDR_GEN_ERR_EN
    ,
    output logic                  o_err,
    output logic [2:0]            o_err_code
`endif
);

    typedef enum logic {IDLE, BURST} state_t;
    typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_t;

    state_t state, state_nxt;
    mode_t  mode_q, mode_in;

    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt, base_q, wend_q;
    logic [ADDR_WIDTH-1:0] span_in, base_in, bytes_q, wrap_inc;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [8:0]            cnt_q;
    logic [2:0]            size_q, size_eff;
    logic                  rdy_q, last_int, wrap_ok;
    logic                  aw_hs, beat_hs;

    assign last_int     = (cnt_q == {1'b0, len_q});
    assign o_beat_valid = (state == BURST);
    assign o_beat_last  = o_beat_valid && last_int;
    assign o_beat_addr  = addr_q;
    assign o_beat_id    = id_q;
    assign i_awready    = rdy_q && ((state == IDLE) || (o_beat_ready && last_int));
    assign aw_hs        = i_awvalid && i_awready;
    assign beat_hs      = o_beat_valid && o_beat_ready;

    if (LW > 0) begin : g_lane
        assign o_beat_lane = addr_q[LANE_W-1:0];
    end else begin : g_nolane
        assign o_beat_lane = 1'b0;
    end

    // Decode of the incoming AW request; only sampled on the handshake.
    always_comb begin
        wrap_ok  = (i_awlen == 8'd1) || (i_awlen == 8'd3) ||
                   (i_awlen == 8'd7) || (i_awlen == 8'd15);
        size_eff = (i_awsize > 3'(LW)) ? 3'(LW) : i_awsize;
        mode_in  = M_INCR;
        unique case (1'b1)
            (i_awburst == 2'd0):            mode_in = M_FIXED;
            (i_awburst == 2'd2) && wrap_ok: mode_in = M_WRAP;
            default:                        mode_in = M_INCR;
        endcase
        span_in = (ADDR_WIDTH'(i_awlen) + ADDR_WIDTH'(1)) << size_eff;
        base_in = i_awaddr & ~(span_in - ADDR_WIDTH'(1));
    end

    always_comb begin
        bytes_q  = ADDR_WIDTH'(1) << size_q;
        wrap_inc = addr_q + bytes_q;
        addr_nxt = (addr_q & ~(bytes_q - ADDR_WIDTH'(1))) + bytes_q;
        unique case (1'b1)
            (mode_q == M_FIXED): addr_nxt = addr_q;
            (mode_q == M_WRAP):  addr_nxt = (wrap_inc == wend_q) ? base_q : wrap_inc;
            default:             addr_nxt = (addr_q & ~(bytes_q - ADDR_WIDTH'(1))) + bytes_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (aw_hs) state_nxt = BURST;
            BURST:   if (beat_hs && last_int && !aw_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= 1'b1;
        end
    end

    // A new AW wins over the final beat advance when both land on one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            base_q <= '0;
            wend_q <= '0;
            id_q   <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            size_q <= '0;
            mode_q <= M_FIXED;
        end else if (aw_hs) begin
            addr_q <= i_awaddr;
            base_q <= base_in;
            wend_q <= base_in + span_in;
            id_q   <= i_awid;
            len_q  <= i_awlen;
            cnt_q  <= '0;
            size_q <= size_eff;
            mode_q <= mode_in;
        end else if (beat_hs) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q + 9'd1;
        end
    end

`ifdef AXI_BURST_ADDR_GEN_ERR_EN
    logic [2:0]  code_in;
    logic [16:0] lo_in, bmask_in, tot_in;

    always_comb begin
        lo_in      = {5'd0, i_awaddr[11:0]};
        bmask_in   = (17'd1 << size_eff) - 17'd1;
        tot_in     = ({9'd0, i_awlen} + 17'd1) << size_eff;
        code_in    = 3'd0;
        code_in[0] = (i_awsize > 3'(LW));
        code_in[1] = (i_awburst == 2'd3) || ((i_awburst == 2'd2) && !wrap_ok);
        code_in[2] = (i_awburst == 2'd1) && (((lo_in & ~bmask_in) + tot_in) > 17'h1000);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_err      <= 1'b0;
            o_err_code <= 3'd0;
        end else begin
            o_err      <= aw_hs && (code_in != 3'd0);
            o_err_code <= aw_hs ? code_in : 3'd0;
        end
    end
`endif

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen at ADDR_WIDTH=12, DATA_WIDTH=32, ID_WIDTH=4.
// Also checks o_err/o_err_code when built with AXI_BURST_ADDR_GEN_ERR_EN.
module tb_axi_burst_addr_gen;

    logic        clk;
    logic        reset_n;
    logic [11:0] i_awaddr;
    logic [7:0]  i_awlen;
    logic [2:0]  i_awsize;
    logic [1:0]  i_awburst;
    logic [3:0]  i_awid;
    logic        i_awvalid;
    logic        i_awready;
    logic [11:0] o_beat_addr;
    logic [1:0]  o_beat_lane;
    logic [3:0]  o_beat_id;
    logic        o_beat_last;
    logic        o_beat_valid;
    logic        o_beat_ready;
`ifdef AXI_BURST_ADDR_GEN_ERR_EN
    logic        o_err;
    logic [2:0]  o_err_code;
`endif

    int tests = 0;
    int failed = 0;
    int hs;

    axi_burst_addr_gen #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(32),
        .ID_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_awaddr(i_awaddr),
        .i_awlen(i_awlen),
        .i_awsize(i_awsize),
        .i_awburst(i_awburst),
        .i_awid(i_awid),
        .i_awvalid(i_awvalid),
        .i_awready(i_awready),
        .o_beat_addr(o_beat_addr),
        .o_beat_lane(o_beat_lane),
        .o_beat_id(o_beat_id),
        .o_beat_last(o_beat_last),
        .o_beat_valid(o_beat_valid),
        .o_beat_ready(o_beat_ready)
`ifdef AXI_BURST_ADDR_GEN_ERR_EN
        ,
        .o_err(o_err),
        .o_err_code(o_err_code)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [11:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt, input logic [3:0] id);
        i_awaddr  = a;
        i_awlen   = len;
        i_awsize  = sz;
        i_awburst = bt;
        i_awid    = id;
        i_awvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i_awready) break;
            step();
        end
        chk("aw_ready", i_awready, 1'b1);
        step();
        i_awvalid = 1'b0;
        i_awaddr  = 12'hFFF;
        i_awlen   = 8'hFF;
    endtask

    task automatic beat(input string tag, input logic [11:0] a,
                        input logic lst, input logic [3:0] id);
        chk({tag, "_valid"}, o_beat_valid, 1'b1);
        chk({tag, "_addr"}, o_beat_addr, a);
        chk({tag, "_lane"}, o_beat_lane, a[1:0]);
        chk({tag, "_last"}, o_beat_last, lst);
        chk({tag, "_id"}, o_beat_id, id);
        step();
    endtask

    initial begin
        reset_n      = 1'b0;
        i_awaddr     = '0;
        i_awlen      = '0;
        i_awsize     = '0;
        i_awburst    = '0;
        i_awid       = '0;
        i_awvalid    = 1'b0;
        o_beat_ready = 1'b1;
        step();
        step();
        chk("rst_valid", o_beat_valid, 1'b0);
        chk("rst_awready", i_awready, 1'b0);
        chk("rst_addr", o_beat_addr, 12'h0);
        chk("rst_last", o_beat_last, 1'b0);
        chk("rst_id", o_beat_id, 4'h0);
        reset_n = 1'b1;
        #1;
        chk("rel_awready_pre", i_awready, 1'b0);
        step();
        chk("rel_awready", i_awready, 1'b1);

        // INCR aligned, latency of one cycle from AW handshake
        send_aw(12'h100, 8'd3, 3'd2, 2'd1, 4'h3);
        beat("incr0", 12'h100, 1'b0, 4'h3);
        beat("incr1", 12'h104, 1'b0, 4'h3);
        beat("incr2", 12'h108, 1'b0, 4'h3);
        beat("incr3", 12'h10C, 1'b1, 4'h3);
        chk("incr_idle", o_beat_valid, 1'b0);

        // WRAP 4 beats of 4 bytes around base 0x30
        send_aw(12'h038, 8'd3, 3'd2, 2'd2, 4'h5);
        beat("wrap0", 12'h038, 1'b0, 4'h5);
        beat("wrap1", 12'h03C, 1'b0, 4'h5);
        beat("wrap2", 12'h030, 1'b0, 4'h5);
        beat("wrap3", 12'h034, 1'b1, 4'h5);

        // Narrow unaligned INCR
        send_aw(12'h101, 8'd2, 3'd0, 2'd1, 4'h6);
        beat("narrow0", 12'h101, 1'b0, 4'h6);
        beat("narrow1", 12'h102, 1'b0, 4'h6);
        beat("narrow2", 12'h103, 1'b1, 4'h6);

        // Illegal WRAP length falls back to INCR
        send_aw(12'h038, 8'd2, 3'd2, 2'd2, 4'h7);
        beat("wrapbad0", 12'h038, 1'b0, 4'h7);
        beat("wrapbad1", 12'h03C, 1'b0, 4'h7);
        beat("wrapbad2", 12'h040, 1'b1, 4'h7);

        // Oversized awsize clamps to 4 bytes
        send_aw(12'h000, 8'd1, 3'd4, 2'd1, 4'h8);
        beat("big0", 12'h000, 1'b0, 4'h8);
        beat("big1", 12'h004, 1'b1, 4'h8);

        // Reserved burst type behaves as INCR
        send_aw(12'h050, 8'd1, 3'd2, 2'd3, 4'h9);
`ifdef AXI_BURST_ADDR_GEN_ERR_EN
        chk("err_pulse", o_err, 1'b1);
        chk("err_code", o_err_code, 3'b010);
`endif
        beat("rsv0", 12'h050, 1'b0, 4'h9);
`ifdef AXI_BURST_ADDR_GEN_ERR_EN
        chk("err_clear", o_err, 1'b0);
`endif
        beat("rsv1", 12'h054, 1'b1, 4'h9);

        // FIXED with downstream stalls on every other cycle
        send_aw(12'h020, 8'd2, 3'd2, 2'd0, 4'hA);
        hs = 0;
        for (int c = 0; c < 12; c++) begin
            if (!o_beat_valid) break;
            o_beat_ready = c[0];
            #1;
            chk("fixed_addr", o_beat_addr, 12'h020);
            chk("fixed_last", o_beat_last, (hs == 2) ? 1'b1 : 1'b0);
            if (o_beat_ready) hs++;
            step();
        end
        chk("fixed_hs", hs, 3);
        chk("fixed_idle", o_beat_valid, 1'b0);
        o_beat_ready = 1'b1;

        // Back-to-back bursts without a bubble
        send_aw(12'h200, 8'd1, 3'd2, 2'd1, 4'h1);
        beat("b2b_a0", 12'h200, 1'b0, 4'h1);
        i_awaddr  = 12'h300;
        i_awlen   = 8'd0;
        i_awsize  = 3'd2;
        i_awburst = 2'd1;
        i_awid    = 4'h2;
        i_awvalid = 1'b1;
        #1;
        chk("b2b_awready", i_awready, 1'b1);
        beat("b2b_a1", 12'h204, 1'b1, 4'h1);
        i_awvalid = 1'b0;
        beat("b2b_b0", 12'h300, 1'b1, 4'h2);
        chk("b2b_idle", o_beat_valid, 1'b0);

        // Reset in the middle of an 8-beat burst
        send_aw(12'h400, 8'd7, 3'd2, 2'd1, 4'hC);
        beat("mid0", 12'h400, 1'b0, 4'hC);
        beat("mid1", 12'h404, 1'b0, 4'hC);
        chk("mid2_addr", o_beat_addr, 12'h408);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_beat_valid, 1'b0);
        chk("mid_rst_awready", i_awready, 1'b0);
        step();
        reset_n = 1'b1;
        #1;
        chk("mid_rel_awready_pre", i_awready, 1'b0);
        step();
        chk("mid_rel_awready", i_awready, 1'b1);
        send_aw(12'h010, 8'd1, 3'd2, 2'd1, 4'hD);
        beat("post0", 12'h010, 1'b0, 4'hD);
        beat("post1", 12'h014, 1'b1, 4'hD);
        chk("post_idle", o_beat_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
